// File: rtl/branch_resolution_if.sv
// Bundle of pipeline-side signals exchanged with the EX-stage branch resolution unit.
// The master side is the surrounding pipeline; the slave side is the resolution unit.
interface branch_resolution_if #(parameter int XLEN = 32);
  logic            clk_enable;
  logic            pipeline_stall;
  logic            IF_branch;
  logic            IF_branch_estimation;
  logic [XLEN-1:0] IF_branch_target;
  logic            EX_branch;
  logic [2:0]      EX_funct3;
  logic [XLEN-1:0] EX_rs1_data;
  logic [XLEN-1:0] EX_rs2_data;
  logic [XLEN-1:0] EX_pc;
  logic [XLEN-1:0] EX_imm;
  logic            EX_branch_taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_IF_ID;
  logic            flush_ID_EX;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output clk_enable, pipeline_stall, IF_branch, IF_branch_estimation, IF_branch_target,
    output EX_branch, EX_funct3, EX_rs1_data, EX_rs2_data, EX_pc, EX_imm,
    input  EX_branch_taken, mispredict, redirect_pc, flush_IF_ID, flush_ID_EX,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  clk_enable, pipeline_stall, IF_branch, IF_branch_estimation, IF_branch_target,
    input  EX_branch, EX_funct3, EX_rs1_data, EX_rs2_data, EX_pc, EX_imm,
    output EX_branch_taken, mispredict, redirect_pc, flush_IF_ID, flush_ID_EX,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolution_unit.sv
// EX-stage branch resolution: tracks IF predictions through ID/EX, resolves the real
// outcome, raises mispredict/redirect/flushes and keeps saturating performance counters.
module branch_resolution_unit #(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                reset,
  branch_resolution_if.slave bus
);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic            id_valid_q, id_valid_d, id_taken_q, id_taken_d;
  logic [XLEN-1:0] id_target_q, id_target_d;
  logic            ex_valid_q, ex_valid_d, ex_taken_q, ex_taken_d;
  logic [XLEN-1:0] ex_target_q, ex_target_d;
  logic [31:0]     branch_count_q, branch_count_d;
  logic [31:0]     mispredict_count_q, mispredict_count_d;

  logic            adv_s, cmp_s, taken_s, pred_taken_s, mispredict_s;
  logic [XLEN-1:0] actual_target_s, fallthrough_s, redirect_s;

  assign adv_s           = bus.clk_enable & ~bus.pipeline_stall;
  assign actual_target_s = bus.EX_pc + bus.EX_imm;
  assign fallthrough_s   = bus.EX_pc + XLEN'(32'd4);
  assign taken_s         = bus.EX_branch & cmp_s;
  // An invalid EX slot stands for a branch the predictor saw as not-taken.
  assign pred_taken_s    = ex_valid_q & ex_taken_q;
  assign mispredict_s    = ~reset & adv_s & bus.EX_branch &
                           ((taken_s != pred_taken_s) |
                            (taken_s & pred_taken_s & (ex_target_q != actual_target_s)));

  always_comb begin
    cmp_s = 1'b0;
    case (bus.EX_funct3)
      3'b000:  cmp_s = (bus.EX_rs1_data == bus.EX_rs2_data);
      3'b001:  cmp_s = (bus.EX_rs1_data != bus.EX_rs2_data);
      3'b100:  cmp_s = ($signed(bus.EX_rs1_data) <  $signed(bus.EX_rs2_data));
      3'b101:  cmp_s = ($signed(bus.EX_rs1_data) >= $signed(bus.EX_rs2_data));
      3'b110:  cmp_s = (bus.EX_rs1_data <  bus.EX_rs2_data);
      3'b111:  cmp_s = (bus.EX_rs1_data >= bus.EX_rs2_data);
      default: cmp_s = 1'b0;
    endcase
  end

  always_comb begin
    redirect_s = {XLEN{1'b0}};
    if (mispredict_s) begin
      redirect_s = taken_s ? actual_target_s : fallthrough_s;
    end else begin
      redirect_s = {XLEN{1'b0}};
    end
  end

  always_comb begin
    id_valid_d         = id_valid_q;
    id_taken_d         = id_taken_q;
    id_target_d        = id_target_q;
    ex_valid_d         = ex_valid_q;
    ex_taken_d         = ex_taken_q;
    ex_target_d        = ex_target_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (adv_s) begin
      // A mispredict squashes both tracked slots so they cannot fire again.
      if (mispredict_s) begin
        id_valid_d  = 1'b0;
        id_taken_d  = 1'b0;
        id_target_d = {XLEN{1'b0}};
        ex_valid_d  = 1'b0;
        ex_taken_d  = 1'b0;
        ex_target_d = {XLEN{1'b0}};
      end else begin
        ex_valid_d  = id_valid_q;
        ex_taken_d  = id_taken_q;
        ex_target_d = id_target_q;
        id_valid_d  = bus.IF_branch;
        id_taken_d  = bus.IF_branch_estimation;
        id_target_d = bus.IF_branch_target;
      end
      if (bus.EX_branch) begin
        branch_count_d = (branch_count_q != CNT_MAX) ? branch_count_q + 32'd1 : branch_count_q;
        if (mispredict_s && (mispredict_count_q != CNT_MAX)) begin
          mispredict_count_d = mispredict_count_q + 32'd1;
        end else begin
          mispredict_count_d = mispredict_count_q;
        end
      end else begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
      end
    end else begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q         <= 1'b0;
      id_taken_q         <= 1'b0;
      id_target_q        <= {XLEN{1'b0}};
      ex_valid_q         <= 1'b0;
      ex_taken_q         <= 1'b0;
      ex_target_q        <= {XLEN{1'b0}};
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      id_valid_q         <= id_valid_d;
      id_taken_q         <= id_taken_d;
      id_target_q        <= id_target_d;
      ex_valid_q         <= ex_valid_d;
      ex_taken_q         <= ex_taken_d;
      ex_target_q        <= ex_target_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.EX_branch_taken  = taken_s;
  assign bus.mispredict       = mispredict_s;
  assign bus.redirect_pc      = redirect_s;
  assign bus.flush_IF_ID      = mispredict_s;
  assign bus.flush_ID_EX      = mispredict_s;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit: a prediction-tracking reference model is
// compared every cycle, and literal expectations pin the model at each scenario.
module tb_branch_resolution_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic live;
  logic preload;

  branch_resolution_if #(.XLEN(32)) bus ();

  branch_resolution_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        t;
    logic [31:0] tgt;
  } pred_t;

  pred_t       m_id, m_ex;
  logic [31:0] m_bc, m_mc;

  function automatic logic ref_cmp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_taken();
    return bus.EX_branch & ref_cmp(bus.EX_funct3, bus.EX_rs1_data, bus.EX_rs2_data);
  endfunction

  function automatic logic m_mp();
    logic tk, pt;
    tk = m_taken();
    pt = m_ex.v & m_ex.t;
    if (reset || !bus.clk_enable || bus.pipeline_stall || !bus.EX_branch) return 1'b0;
    return (tk != pt) || (tk && pt && (m_ex.tgt != bus.EX_pc + bus.EX_imm));
  endfunction

  function automatic logic [31:0] m_redirect();
    if (!m_mp()) return 32'd0;
    return m_taken() ? bus.EX_pc + bus.EX_imm : bus.EX_pc + 32'd4;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Reference model: predictions advance one slot per advancing edge.
  always @(posedge clk) begin : model
    logic [31:0] base_bc, base_mc;
    base_bc = preload ? 32'hFFFF_FFFE : m_bc;
    base_mc = preload ? 32'hFFFF_FFFE : m_mc;
    m_bc <= base_bc;
    m_mc <= base_mc;
    if (reset) begin
      m_id <= '0;
      m_ex <= '0;
      m_bc <= 32'd0;
      m_mc <= 32'd0;
    end else if (bus.clk_enable && !bus.pipeline_stall) begin
      if (m_mp()) begin
        m_id <= '0;
        m_ex <= '0;
      end else begin
        m_ex <= m_id;
        m_id <= {bus.IF_branch, bus.IF_branch_estimation, bus.IF_branch_target};
      end
      if (bus.EX_branch) begin
        m_bc <= sat_inc(base_bc);
        m_mc <= m_mp() ? sat_inc(base_mc) : base_mc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("mdl_ex_taken", bus.EX_branch_taken, m_taken());
    chk("mdl_mispredict", bus.mispredict, m_mp());
    chk("mdl_redirect", bus.redirect_pc, m_redirect());
    chk("mdl_flush_if_id", bus.flush_IF_ID, m_mp());
    chk("mdl_flush_id_ex", bus.flush_ID_EX, m_mp());
    chk("mdl_branch_count", bus.branch_count, preload ? 32'hFFFF_FFFE : m_bc);
    chk("mdl_mispredict_count", bus.mispredict_count, preload ? 32'hFFFF_FFFE : m_mc);
  endtask

  task automatic half();
    @(negedge clk);
    if (live) compare_model();
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic t, input logic [31:0] tgt);
    bus.IF_branch = 1'b1; bus.IF_branch_estimation = t; bus.IF_branch_target = tgt;
    half(); edge_();
    bus.IF_branch = 1'b0; bus.IF_branch_estimation = 1'b0; bus.IF_branch_target = 32'd0;
    half(); edge_();
  endtask

  task automatic set_ex(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm);
    bus.EX_branch = 1'b1; bus.EX_funct3 = f; bus.EX_rs1_data = a;
    bus.EX_rs2_data = b; bus.EX_pc = pc; bus.EX_imm = imm;
  endtask

  task automatic clr_ex();
    set_ex(3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.EX_branch = 1'b0;
  endtask

  task automatic counts(input string name, input logic [31:0] bc, input logic [31:0] mc);
    chk({name, "_branch_count"}, bus.branch_count, bc);
    chk({name, "_mispredict_count"}, bus.mispredict_count, mc);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, pc, imm;
    logic        tk;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs [6];

  initial begin
    checks = 0; errors = 0; live = 1'b0; preload = 1'b0;
    vecs[0] = '{3'd5, 32'h8000_0000, 32'd1, 32'h800, 32'h10, 1'b0, 32'h0};
    vecs[1] = '{3'd6, 32'd1, 32'h8000_0000, 32'h800, 32'h10, 1'b1, 32'h810};
    vecs[2] = '{3'd2, 32'd0, 32'd0, 32'h800, 32'h10, 1'b0, 32'h0};
    vecs[3] = '{3'd3, 32'd5, 32'd5, 32'h800, 32'h10, 1'b0, 32'h0};
    vecs[4] = '{3'd5, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10};
    vecs[5] = '{3'd4, 32'd1, 32'hFFFF_FFFF, 32'h800, 32'h10, 1'b0, 32'h0};

    reset = 1'b1; bus.clk_enable = 1'b1; bus.pipeline_stall = 1'b0;
    bus.IF_branch = 1'b0; bus.IF_branch_estimation = 1'b0; bus.IF_branch_target = 32'd0;
    clr_ex();
    edge_(); edge_();
    reset = 1'b0; live = 1'b1;
    repeat (5) begin half(); edge_(); end
    half();
    chk("idle_mispredict", bus.mispredict, 32'd0);
    chk("idle_redirect", bus.redirect_pc, 32'd0);
    counts("idle", 32'd0, 32'd0);
    edge_();

    // BEQ taken, predicted not-taken
    issue(1'b0, 32'd0);
    set_ex(3'd0, 32'd5, 32'd5, 32'h100, 32'h40);
    half();
    chk("beq_taken", bus.EX_branch_taken, 32'd1);
    chk("beq_mispredict", bus.mispredict, 32'd1);
    chk("beq_redirect", bus.redirect_pc, 32'h140);
    chk("beq_flush", {bus.flush_IF_ID, bus.flush_ID_EX}, 32'd3);
    edge_(); clr_ex(); half();
    chk("beq_flush_drop", {bus.flush_IF_ID, bus.flush_ID_EX}, 32'd0);
    counts("beq", 32'd1, 32'd1);
    edge_();

    // BNE not-taken, predicted taken, with taken predictions queued behind it
    bus.IF_branch = 1'b1; bus.IF_branch_estimation = 1'b1; bus.IF_branch_target = 32'h208;
    half(); edge_();
    bus.IF_branch_target = 32'h999;
    half(); edge_();
    set_ex(3'd1, 32'd7, 32'd7, 32'h200, 32'h40);
    half();
    chk("bne_taken", bus.EX_branch_taken, 32'd0);
    chk("bne_mispredict", bus.mispredict, 32'd1);
    chk("bne_redirect", bus.redirect_pc, 32'h204);
    edge_();
    bus.IF_branch = 1'b0; bus.IF_branch_estimation = 1'b0; bus.IF_branch_target = 32'd0;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("bne_stale_mispredict", bus.mispredict, 32'd0);
      edge_();
    end
    clr_ex(); half(); counts("bne", 32'd4, 32'd2); edge_();

    // BLT correctly predicted taken
    issue(1'b1, 32'h300);
    set_ex(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h2F0, 32'h10);
    half();
    chk("blt_taken", bus.EX_branch_taken, 32'd1);
    chk("blt_mispredict", bus.mispredict, 32'd0);
    chk("blt_flush", bus.flush_IF_ID, 32'd0);
    edge_(); clr_ex(); half(); counts("blt", 32'd5, 32'd2); edge_();

    // BGEU taken with wrong predicted target
    issue(1'b1, 32'h500);
    set_ex(3'd7, 32'd9, 32'd3, 32'h400, 32'h80);
    half();
    chk("bgeu_mispredict", bus.mispredict, 32'd1);
    chk("bgeu_redirect", bus.redirect_pc, 32'h480);
    edge_(); clr_ex(); half(); counts("bgeu", 32'd6, 32'd3); edge_();

    // Stall for three cycles with a mispredicting branch in EX
    issue(1'b0, 32'd0);
    set_ex(3'd0, 32'd3, 32'd3, 32'h600, 32'h20);
    bus.pipeline_stall = 1'b1;
    repeat (3) begin
      half();
      chk("stall_taken", bus.EX_branch_taken, 32'd1);
      chk("stall_mispredict", bus.mispredict, 32'd0);
      chk("stall_flush", bus.flush_ID_EX, 32'd0);
      edge_();
    end
    bus.pipeline_stall = 1'b0;
    half();
    chk("stall_release_mispredict", bus.mispredict, 32'd1);
    chk("stall_release_redirect", bus.redirect_pc, 32'h620);
    edge_(); clr_ex(); half(); counts("stall", 32'd7, 32'd4); edge_();

    // clk_enable low holds everything for a cycle
    set_ex(3'd0, 32'd1, 32'd1, 32'h700, 32'h8);
    bus.clk_enable = 1'b0;
    half(); chk("cen_mispredict", bus.mispredict, 32'd0); edge_();
    bus.clk_enable = 1'b1;
    half();
    chk("cen_release_mispredict", bus.mispredict, 32'd1);
    chk("cen_release_redirect", bus.redirect_pc, 32'h708);
    edge_(); clr_ex(); half(); counts("cen", 32'd8, 32'd5); edge_();

    // Branch types against an invalid (predicted not-taken) slot
    foreach (vecs[i]) begin
      set_ex(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm);
      half();
      chk("vec_taken", bus.EX_branch_taken, vecs[i].tk);
      chk("vec_mispredict", bus.mispredict, vecs[i].tk);
      chk("vec_redirect", bus.redirect_pc, vecs[i].rd);
      edge_();
    end
    clr_ex(); half(); counts("vec", 32'd14, 32'd7); edge_();

    // Fallthrough wraps past the top of the address space
    issue(1'b1, 32'h40);
    set_ex(3'd1, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h40);
    half();
    chk("wrap_mispredict", bus.mispredict, 32'd1);
    chk("wrap_redirect", bus.redirect_pc, 32'd0);
    edge_(); clr_ex(); half(); counts("wrap", 32'd15, 32'd8); edge_();

    // Saturation from a preloaded near-maximum count
    force dut.branch_count_q = 32'hFFFF_FFFE;
    force dut.mispredict_count_q = 32'hFFFF_FFFE;
    preload = 1'b1;
    #1;
    release dut.branch_count_q;
    release dut.mispredict_count_q;
    set_ex(3'd0, 32'd2, 32'd2, 32'h900, 32'h4);
    half(); counts("sat_pre", 32'hFFFF_FFFE, 32'hFFFF_FFFE); edge_();
    preload = 1'b0;
    half(); counts("sat_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF); edge_();
    half(); counts("sat_hold", 32'hFFFF_FFFF, 32'hFFFF_FFFF); edge_();

    // Reset wins over a pending mispredict
    reset = 1'b1; live = 1'b0;
    set_ex(3'd0, 32'd4, 32'd4, 32'hA00, 32'h8);
    half(); chk("rst_mispredict", bus.mispredict, 32'd0); edge_();
    reset = 1'b0; live = 1'b1; clr_ex();
    half(); counts("rst", 32'd0, 32'd0); edge_();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
